// File: rtl/matrix_result_collector.sv
// Collects row results from the processor array in strict row order
// and pushes them into the output FIFO; reports done or error.
module matrix_result_collector #(
  parameter int DATA_W   = 8,
  parameter int N_PROC   = 4,
  parameter int MAX_SIZE = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [DATA_W-1:0]        size,
  input  logic [N_PROC-1:0]        res_valid,
  input  logic [N_PROC*DATA_W-1:0] res_data,
  output logic [N_PROC-1:0]        res_ack,
  input  logic                     fifo_full,
  output logic                     fifo_push,
  output logic [DATA_W-1:0]        fifo_data,
  output logic                     busy,
  output logic [DATA_W-1:0]        row_cnt,
  output logic                     done,
  output logic                     err
);

  localparam int IW = $clog2(N_PROC);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] MAX_V = DATA_W'(MAX_SIZE);
  localparam logic [TW-1:0]     TMO   = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [N_PROC-1:0]   res_ack_q, res_ack_d;
  logic                fifo_push_q, fifo_push_d;
  logic [DATA_W-1:0]   fifo_data_q, fifo_data_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   row_cnt_q, row_cnt_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   size_q, size_d;
  logic [TW-1:0]       timer_q, timer_d;

  logic [IW-1:0]       idx;
  logic [DATA_W-1:0]   sel_data;
  logic [DATA_W-1:0]   row_nx;
  logic                take;

  assign idx    = row_cnt_q[IW-1:0];
  assign row_nx = row_cnt_q + DATA_W'(1);
  assign take   = res_valid[idx] && !fifo_full;

  always_comb begin
    sel_data = '0;
    for (int p = 0; p < N_PROC; p++) begin
      if (idx == IW'(p)) sel_data = res_data[p*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    res_ack_d   = '0;
    fifo_push_d = 1'b0;
    fifo_data_d = '0;
    row_cnt_d   = row_cnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    size_d      = size_q;
    timer_d     = timer_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (size != '0 && size <= MAX_V) begin
            size_d    = size;
            row_cnt_d = '0;
            timer_d   = '0;
            state_d   = WAIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (take) begin
          fifo_push_d    = 1'b1;
          fifo_data_d    = sel_data;
          res_ack_d[idx] = 1'b1;
          row_cnt_d      = row_nx;
          timer_d        = '0;
          if (row_nx == size_q) state_d = DONE;
        end else if (timer_q == TMO) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == WAIT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      res_ack_q   <= '0;
      fifo_push_q <= 1'b0;
      fifo_data_q <= '0;
      busy_q      <= 1'b0;
      row_cnt_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      size_q      <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      res_ack_q   <= res_ack_d;
      fifo_push_q <= fifo_push_d;
      fifo_data_q <= fifo_data_d;
      busy_q      <= busy_d;
      row_cnt_q   <= row_cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      size_q      <= size_d;
      timer_q     <= timer_d;
    end
  end

  assign res_ack   = res_ack_q;
  assign fifo_push = fifo_push_q;
  assign fifo_data = fifo_data_q;
  assign busy      = busy_q;
  assign row_cnt   = row_cnt_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
